spi_cs_demux: RTL

//  Parametrised SPI chip-select demultiplexer. Counts SCLK edges inside one master CS-low window
//  and routes successive BITS_PER_CH-bit slices to NUM_CH one-hot downstream chip selects.

---
 rtl/spi_cs_demux_if.sv | 69 ++++++
 rtl/spi_cs_demux.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/spi_cs_demux_if.sv
// ---------------------------------------------------------------------------
// spi_cs_demux_if
//   Bundles the upstream SPI master pins and the downstream chip-select /
//   status signals of spi_cs_demux.
//
//   Parameters
//     NUM_CH       number of downstream chip selects
//     BITS_PER_CH  SCLK edges per channel slice
//
//   Signals
//     spi_clk     raw SPI SCLK from the master (asynchronous)
//     spi_cs      raw SPI CS from the master, active-low (asynchronous)
//     cs_out      one-hot downstream chip selects
//     ch_idx      index of the currently selected channel
//     bit_cnt     edges counted in the current slice
//     busy        demux is routing a frame
//     ch_done     1-cycle pulse when a slice completes
//     frame_done  1-cycle pulse when the last channel's slice completes
//     abort       1-cycle pulse when CS deasserts mid-slice
//     overrun     sticky flag: SCLK edge arrived after the frame stopped
//
//   Modports
//     slave   the demux itself (consumes pins, drives selects and status)
//     master  the environment (drives pins, observes selects and status)
// ---------------------------------------------------------------------------
interface spi_cs_demux_if #(
    parameter int NUM_CH      = 7,
    parameter int BITS_PER_CH = 96
);
    localparam int CH_W  = ($clog2(NUM_CH) > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = ($clog2(BITS_PER_CH) > 1) ? $clog2(BITS_PER_CH) : 1;

    logic              spi_clk;
    logic              spi_cs;
    logic [NUM_CH-1:0] cs_out;
    logic [CH_W-1:0]   ch_idx;
    logic [CNT_W-1:0]  bit_cnt;
    logic              busy;
    logic              ch_done;
    logic              frame_done;
    logic              abort;
    logic              overrun;

    modport slave (
        input  spi_clk,
        input  spi_cs,
        output cs_out,
        output ch_idx,
        output bit_cnt,
        output busy,
        output ch_done,
        output frame_done,
        output abort,
        output overrun
    );

    modport master (
        output spi_clk,
        output spi_cs,
        input  cs_out,
        input  ch_idx,
        input  bit_cnt,
        input  busy,
        input  ch_done,
        input  frame_done,
        input  abort,
        input  overrun
    );
endinterface

// File: rtl/spi_cs_demux.sv
// ---------------------------------------------------------------------------
// spi_cs_demux
//   SPI chip-select demultiplexer. While the master holds CS low, SCLK edges
//   are counted and every BITS_PER_CH edges the downstream chip select
//   advances to the next of NUM_CH channels. After the last channel the
//   demux either stops (overrun flags further edges) or wraps to channel 0.
//   All logic runs on sys_clk; the SPI pins are synchronised first.
//
//   Ports
//     sys_clk   system clock, rising edge
//     sys_rst   asynchronous active-high reset
//     bus       spi_cs_demux_if.slave
//                 in : spi_clk, spi_cs (raw, asynchronous, CS active-low)
//                 out: cs_out, ch_idx, bit_cnt, busy, ch_done, frame_done,
//                      abort, overrun
//
//   Pin-to-state latency is SYNC_STAGES+1 sys_clk cycles. SCLK must run
//   slower than sys_clk/(2*(SYNC_STAGES+1)).
// ---------------------------------------------------------------------------
module spi_cs_demux #(
    parameter int NUM_CH      = 7,
    parameter int BITS_PER_CH = 96,
    parameter int SYNC_STAGES = 2,
    parameter int SAMPLE_EDGE = 0,   // 0: count rising SCLK, 1: count falling
    parameter int WRAP_MODE   = 0,   // 0: stop after last channel, 1: wrap
    parameter int OUT_ACT_LOW = 0    // 0: cs_out active-high, 1: active-low
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    spi_cs_demux_if.slave bus
);
    localparam int CH_W  = ($clog2(NUM_CH) > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = ($clog2(BITS_PER_CH) > 1) ? $clog2(BITS_PER_CH) : 1;

    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BITS_PER_CH - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACTIVE  = 2'd1,
        ST_STOPPED = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // Pin synchronisers and SCLK edge detect
    // -----------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic                   sclk_d;
    logic                   sclk_s;
    logic                   cs_s;
    logic                   sclk_evt;

    // NOTE: CS flops reset to 1 (deasserted) so leaving reset never looks
    // like a frame start; SCLK flops and the edge register reset to the same
    // level so no phantom edge is seen either.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            sclk_d    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge value of its neighbour; blocking here would collapse
            // the synchroniser chain into a single stage.
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.spi_clk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.spi_cs};
            sclk_d    <= sclk_s;
        end
    end

    assign sclk_s   = sclk_sync[SYNC_STAGES-1];
    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign sclk_evt = (SAMPLE_EDGE != 0) ? (sclk_d & ~sclk_s) : (sclk_s & ~sclk_d);

    // -----------------------------------------------------------------------
    // Control FSM
    // -----------------------------------------------------------------------
    state_t           state,        state_n;
    logic [CH_W-1:0]  ch_q,         ch_n;
    logic [CNT_W-1:0] bit_q,        bit_n;
    logic             ch_done_q,    ch_done_n;
    logic             frame_done_q, frame_done_n;
    logic             abort_q,      abort_n;
    logic             overrun_q,    overrun_n;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state        <= ST_IDLE;
            ch_q         <= '0;
            bit_q        <= '0;
            ch_done_q    <= 1'b0;
            frame_done_q <= 1'b0;
            abort_q      <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state        <= state_n;
            ch_q         <= ch_n;
            bit_q        <= bit_n;
            ch_done_q    <= ch_done_n;
            frame_done_q <= frame_done_n;
            abort_q      <= abort_n;
            overrun_q    <= overrun_n;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default up front so no
        // path through the case leaves one unassigned (which would infer a
        // latch). Pulses default to 0, state and counters default to hold.
        state_n      = state;
        ch_n         = ch_q;
        bit_n        = bit_q;
        ch_done_n    = 1'b0;
        frame_done_n = 1'b0;
        abort_n      = 1'b0;
        overrun_n    = overrun_q;

        if (cs_s) begin
            // CS deassert overrides everything, including a coincident edge.
            state_n   = ST_IDLE;
            ch_n      = '0;
            bit_n     = '0;
            overrun_n = 1'b0;
            abort_n   = (state == ST_ACTIVE) && (bit_q != '0);
        end else begin
            case (state)
                ST_IDLE: begin
                    state_n = ST_ACTIVE;
                    ch_n    = '0;
                    bit_n   = '0;
                end

                ST_ACTIVE: begin
                    if (sclk_evt) begin
                        if (bit_q != LAST_BIT) begin
                            bit_n = bit_q + CNT_W'(1);
                        end else begin
                            bit_n     = '0;
                            ch_done_n = 1'b1;
                            if (ch_q != LAST_CH) begin
                                ch_n = ch_q + CH_W'(1);
                            end else begin
                                frame_done_n = 1'b1;
                                if (WRAP_MODE != 0) begin
                                    ch_n = '0;
                                end else begin
                                    // ch_idx stays on the last channel while stopped.
                                    state_n = ST_STOPPED;
                                end
                            end
                        end
                    end
                end

                ST_STOPPED: begin
                    if (sclk_evt) begin
                        overrun_n = 1'b1;
                    end
                end

                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    // The select is decoded straight from the registered channel index, so
    // a channel switch moves the active bit in one cycle with no gap.
    logic [NUM_CH-1:0] sel;

    always_comb begin
        sel = '0;
        if (state == ST_ACTIVE) begin
            sel[ch_q] = 1'b1;
        end
    end

    assign bus.cs_out     = (OUT_ACT_LOW != 0) ? ~sel : sel;
    assign bus.ch_idx     = ch_q;
    assign bus.bit_cnt    = bit_q;
    assign bus.busy       = (state == ST_ACTIVE);
    assign bus.ch_done    = ch_done_q;
    assign bus.frame_done = frame_done_q;
    assign bus.abort      = abort_q;
    assign bus.overrun    = overrun_q;

endmodule
